// File: rtl/tx_pkg.sv
// Shared types and constants for the TX gearbox and its PRBS7 pattern source.
package tx_pkg;
  localparam int SERDES_STAGES = 2;
  localparam int TX_OUT_W      = 2**SERDES_STAGES;

  typedef enum logic [1:0] {
    DATA   = 2'd0,
    CLKPAT = 2'd1,
    PRBS   = 2'd2,
    ZERO   = 2'd3
  } tx_mode_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    STREAM  = 2'd1,
    STARVED = 2'd2,
    PATTERN = 2'd3
  } tx_gb_state_e;

  // x^7 + x^6 + 1: taps are the bits generated 7 and 6 steps ago.
  localparam logic [6:0] PRBS7_SEED   = 7'h7F;
  localparam int         PRBS7_TAP_HI = 6;
  localparam int         PRBS7_TAP_LO = 5;

  function automatic logic [TX_OUT_W-1:0] clk_pattern();
    logic [TX_OUT_W-1:0] p;
    for (int i = 0; i < TX_OUT_W; i++) p[i] = i[0];
    return p;
  endfunction
endpackage

// File: rtl/tx_prbs7.sv
// PRBS7 (x^7+x^6+1) source emitting W bits per advance, q[0] being the oldest bit.
// Compiled only when TX_GEARBOX_PRBS_EN is defined.
`ifdef TX_GEARBOX_PRBS_EN
module tx_prbs7
  import tx_pkg::*;
#(
  parameter int W = TX_OUT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         adv,
  output logic [W-1:0] q
);
  logic [6:0] lfsr_reg;
  logic [6:0] lfsr_next;
  logic       fb;

  always_comb begin
    lfsr_next = lfsr_reg;
    q         = '0;
    fb        = 1'b0;
    for (int i = 0; i < W; i++) begin
      fb        = lfsr_next[PRBS7_TAP_HI] ^ lfsr_next[PRBS7_TAP_LO];
      q[i]      = fb;
      lfsr_next = {lfsr_next[5:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_reg <= PRBS7_SEED;
    else if (adv) lfsr_reg <= lfsr_next;
  end
endmodule
`endif

// File: rtl/tx_gearbox.sv
// Narrows IN_W-bit words to OUT_W-bit slices (LSB slice first) for txdata.din, with idle/pattern fill.
// Define TX_GEARBOX_PRBS_EN to make mode 2 emit PRBS7; otherwise mode 2 emits zeros.
module tx_gearbox
  import tx_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = TX_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] dout,
  output logic [15:0]      underrun_cnt,
  input  logic             cnt_clr
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  tx_gb_state_e     state_reg;
  logic [IN_W-1:0]  nxt_reg;
  logic [IN_W-1:0]  act_reg;
  logic             nxt_full_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [OUT_W-1:0] dout_reg;
  logic [15:0]      cnt_reg;

  tx_mode_e         mode_e;
  logic             is_data;
  logic             last_slice;
  logic             boundary;
  logic             consume;
  logic             enter_pat;
  logic             underrun;
  logic             accept;
  logic [OUT_W-1:0] pattern;
  logic [OUT_W-1:0] act_slice [RATIO];

  for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
    assign act_slice[gi] = act_reg[gi*OUT_W +: OUT_W];
  end

  assign mode_e     = tx_mode_e'(mode);
  assign is_data    = (mode_e == DATA);
  assign last_slice = (idx_reg == LAST_IDX);
  // Word boundaries are the only points where reloads and mode changes take effect.
  assign boundary   = (state_reg == IDLE) || (state_reg == STARVED) ||
                      ((state_reg == STREAM) && last_slice);
  assign consume    = boundary && is_data && nxt_full_reg;
  assign enter_pat  = boundary && !is_data;
  assign underrun   = (state_reg == STREAM) && last_slice && is_data && !nxt_full_reg;
  assign in_ready   = !rst && is_data && (!nxt_full_reg || consume);
  assign accept     = in_valid && in_ready;

`ifdef TX_GEARBOX_PRBS_EN
  logic [OUT_W-1:0] prbs_q;
  logic             prbs_adv;

  assign prbs_adv = (state_reg == PATTERN) && (mode_e == PRBS);

  tx_prbs7 #(.W(OUT_W)) u_prbs7 (
    .clk (clk),
    .rst (rst),
    .adv (prbs_adv),
    .q   (prbs_q)
  );
`endif

  always_comb begin
    pattern = '0;
    case (mode_e)
      CLKPAT:  pattern = clk_pattern();
`ifdef TX_GEARBOX_PRBS_EN
      PRBS:    pattern = prbs_q;
`endif
      default: pattern = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      nxt_reg      <= '0;
      act_reg      <= '0;
      nxt_full_reg <= 1'b0;
      idx_reg      <= '0;
      dout_reg     <= '0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE, STARVED: begin
          dout_reg <= '0;
          if (enter_pat) state_reg <= PATTERN;
          else if (consume) state_reg <= STREAM;
        end
        STREAM: begin
          dout_reg <= act_slice[idx_reg];
          idx_reg  <= last_slice ? '0 : idx_reg + 1'b1;
          if (enter_pat) state_reg <= PATTERN;
          else if (underrun) state_reg <= STARVED;
        end
        default: begin
          dout_reg <= pattern;
          if (is_data) state_reg <= IDLE;
        end
      endcase

      if (consume) act_reg <= nxt_reg;

      // A word still parked in nxt when a pattern mode takes over is discarded.
      if (accept) begin
        nxt_reg      <= in_data;
        nxt_full_reg <= 1'b1;
      end else if (consume || enter_pat) begin
        nxt_full_reg <= 1'b0;
      end

      if (cnt_clr) cnt_reg <= '0;
      else if (underrun && (cnt_reg != 16'hFFFF)) cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign dout         = dout_reg;
  assign underrun_cnt = cnt_reg;
endmodule

// File: tb/tb_tx_gearbox.sv
// Self-checking bench for tx_gearbox with IN_W=32, OUT_W=4: directed sequences,
// a mode table, and random DATA traffic against a word-schedule reference model.
module tb_tx_gearbox;
  import tx_pkg::*;

  localparam int IN_W  = 32;
  localparam int OUT_W = 4;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       mode = DATA;
  logic [IN_W-1:0]  in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [OUT_W-1:0] dout;
  logic [15:0]      underrun_cnt;
  logic             cnt_clr = 1'b0;

  always #5 clk = ~clk;

  tx_gearbox #(.IN_W(IN_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dout         (dout),
    .underrun_cnt (underrun_cnt),
    .cnt_clr      (cnt_clr)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [3:0] exp_dout;
    logic       exp_ready;
  } mode_vec_t;

  typedef struct {
    logic [31:0] data;
    int          start;
  } sched_t;

  mode_vec_t   mvec[$];
  sched_t      sq[$];
  logic [3:0]  hist [0:1023];
  int          acc_t [0:63];
  int          w, cyc, last_end, last_load, m_cnt, pct, ld;
  logic        took, exp_ready;
  logic [3:0]  exp_dout;
  logic [31:0] sh;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; cnt_clr = 1'b0; mode = DATA;
    #1;
    check("ready_during_reset", in_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_dout", dout, 0);
    check("reset_cnt", underrun_cnt, 0);
    check("reset_ready_after", in_ready, 1);
  endtask

  task automatic send_word(input logic [31:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    check("send_accept", done, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mvec.push_back('{"mode_clkpat", CLKPAT, 4'hA, 1'b0});
`ifndef TX_GEARBOX_PRBS_EN
    mvec.push_back('{"mode_prbs_off", PRBS, 4'h0, 1'b0});
`endif
    mvec.push_back('{"mode_clkpat2", CLKPAT, 4'hA, 1'b0});
    mvec.push_back('{"mode_zero", ZERO, 4'h0, 1'b0});
    mvec.push_back('{"mode_data", DATA, 4'h0, 1'b1});

    @(negedge clk);
    do_reset();

    // Single word: slices 1..8 after edge k+2, then starvation.
    send_word(32'h8765_4321);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("single_slice%0d", i), dout, (i >= 2 && i <= 9) ? i - 1 : 0);
      tick();
    end
    check("single_underrun", underrun_cnt, 1);

    // Reset during slice 5 drops the rest of the word and the counter.
    send_word(32'h7654_3210);
    repeat (7) tick();
    check("rstmid_pre_dout", dout, 5);
    rst = 1'b1;
    #1;
    check("rstmid_ready_in_reset", in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rstmid_dout", dout, 0);
    check("rstmid_ready", in_ready, 1);
    check("rstmid_cnt", underrun_cnt, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rstmid_idle%0d", i), dout, 0);
    end
    check("rstmid_cnt_after", underrun_cnt, 0);

    // Mode switch at slice 3: slices 4..7 finish, queued word is dropped.
    in_valid = 1'b1; in_data = 32'h7654_3210;
    #1;
    check("msw_ready0", in_ready, 1);
    tick();
    in_data = 32'h9999_9999;
    #1;
    check("msw_ready1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("msw_slice3", dout, 3);
    mode = CLKPAT;
    #1;
    check("msw_ready_pat", in_ready, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("msw_out%0d", i), dout, (i < 4) ? 4 + i : 4'hA);
    end
    check("msw_ready_end", in_ready, 0);
    mode = DATA;
    for (int i = 0; i < 12; i++) begin
      tick();
      check($sformatf("msw_dropped%0d", i), dout, 0);
    end
    check("msw_cnt", underrun_cnt, 0);

    // Pattern mode table.
    foreach (mvec[i]) begin
      mode = mvec[i].mode;
      repeat (3) tick();
      check({mvec[i].name, "_dout"}, dout, mvec[i].exp_dout);
      check({mvec[i].name, "_ready"}, in_ready, mvec[i].exp_ready);
    end

    // Back-to-back alternating words.
    do_reset();
    w = 0; cyc = 0;
    in_valid = 1'b1;
    while (w < 64 && cyc < 700) begin
      in_data = (w % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
      #1;
      took = in_ready;
      tick();
      hist[cyc] = dout;
      if (took) begin
        acc_t[w] = cyc;
        w++;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("b2b_accepted", w, 64);
    check("b2b_cnt_streaming", underrun_cnt, 0);
    if (w == 64) begin
      while (cyc < acc_t[0] + 2 + 64 * RATIO + 2 && cyc < 1000) begin
        tick();
        hist[cyc] = dout;
        cyc++;
      end
      check("b2b_gap01", acc_t[1] - acc_t[0], 1);
      for (int i = 2; i < 64; i++) check($sformatf("b2b_gap%0d", i), acc_t[i] - acc_t[i-1], RATIO);
      for (int s = 0; s < 64 * RATIO; s++)
        check($sformatf("b2b_slice%0d", s), hist[acc_t[0] + 2 + s], ((s / RATIO) % 2 == 1) ? 4'hF : 4'h0);
      check("b2b_tail", hist[acc_t[0] + 2 + 64 * RATIO], 0);
      check("b2b_cnt_end", underrun_cnt, 1);
    end

    // Counter saturation and clear-vs-underrun priority.
    do_reset();
    force dut.cnt_reg = 16'hFFFD;
    #1;
    release dut.cnt_reg;
    for (int n = 1; n <= 3; n++) begin
      send_word(32'h1111_1111 * n);
      repeat (12) tick();
      check($sformatf("sat_cnt%0d", n), underrun_cnt, (n < 2) ? 16'hFFFD + n : 16'hFFFF);
    end
    send_word(32'hCAFE_F00D);
    repeat (8) tick();
    check("clr_pre", underrun_cnt, 16'hFFFF);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_wins", underrun_cnt, 0);
    repeat (3) tick();
    check("clr_starved_hold", underrun_cnt, 0);

`ifdef TX_GEARBOX_PRBS_EN
    begin
      bit ref_bits [0:1100];
      for (int n = 0; n < 7; n++) ref_bits[n] = 1'b1;
      for (int n = 7; n <= 1100; n++) ref_bits[n] = ref_bits[n-7] ^ ref_bits[n-6];
      do_reset();
      mode = PRBS;
      tick();
      check("prbs_enter", dout, 0);
      for (int c = 0; c < 254; c++) begin
        tick();
        exp_dout = {ref_bits[7+4*c+3], ref_bits[7+4*c+2], ref_bits[7+4*c+1], ref_bits[7+4*c]};
        check($sformatf("prbs_c%0d", c), dout, exp_dout);
      end
      check("prbs_ready", in_ready, 0);
      mode = DATA;
      tick();
    end
`endif

    // Random DATA traffic against a schedule model: each accepted word is loaded at
    // max(accept+1, previous word's last slice edge) and streams RATIO slices from load+1.
    do_reset();
    sq.delete();
    last_end = -100; last_load = -100; m_cnt = 0;
    for (int e = 0; e < 1500; e++) begin
      pct = ((e / 250) % 3 == 0) ? 95 : (((e / 250) % 3 == 1) ? 20 : 60);
      in_valid = ($urandom_range(0, 99) < pct);
      in_data  = $urandom;
      cnt_clr  = ($urandom_range(0, 63) == 0);
      #1;
      exp_ready = !(last_load > e);
      check($sformatf("rnd_ready_e%0d", e), in_ready, exp_ready);
      if (cnt_clr) m_cnt = 0;
      else if (last_end == e && m_cnt < 65535) m_cnt++;
      if (in_valid && exp_ready) begin
        ld = (last_end > e + 1) ? last_end : e + 1;
        sq.push_back('{in_data, ld + 1});
        last_load = ld;
        last_end  = ld + RATIO;
      end
      tick();
      while (sq.size() > 0 && sq[0].start + RATIO - 1 < e) void'(sq.pop_front());
      exp_dout = 4'h0;
      if (sq.size() > 0 && sq[0].start <= e) begin
        sh = sq[0].data >> (OUT_W * (e - sq[0].start));
        exp_dout = sh[3:0];
      end
      check($sformatf("rnd_dout_e%0d", e), dout, exp_dout);
      check($sformatf("rnd_cnt_e%0d", e), underrun_cnt, m_cnt);
    end
    in_valid = 1'b0;
    cnt_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
